// File: rtl/multicycle_multiply.sv
// rtl/multicycle_multiply.sv - 32x32->64 shift-add multiplier for the HI/LO unit
// Runs MULT/MULTU/MADD/MADDU/MSUB/MSUBU over 32 iterations, stalling the pipeline meanwhile.
module multicycle_multiply (
  input  logic        clock,
  input  logic        reset,
  input  logic        OP_mult,
  input  logic        OP_multu,
  input  logic        OP_madd,
  input  logic        OP_maddu,
  input  logic        OP_msub,
  input  logic        OP_msubu,
  input  logic [31:0] Multiplicand,
  input  logic [31:0] Multiplier,
  input  logic [31:0] HI_in,
  input  logic [31:0] LO_in,
  output logic [31:0] Product_HI,
  output logic [31:0] Product_LO,
  output logic        Stall
);

  typedef enum logic {S_IDLE, S_RUN} state_t;
  typedef enum logic [1:0] {M_NONE = 2'd0, M_ADD = 2'd1, M_SUB = 2'd2} mode_t;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_cycle, w_cycle_nxt;
  logic        r_neg, w_neg_nxt;
  mode_t       r_mode, w_mode_nxt;
  logic [31:0] r_mcand, w_mcand_nxt;
  logic [31:0] r_hi, w_hi_nxt;
  logic [31:0] r_lo, w_lo_nxt;
  logic [63:0] r_acc_in, w_acc_in_nxt;

  logic        w_start;
  logic        w_signed;
  mode_t       w_mode;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_addend;
  logic [32:0] w_sum;
  logic [63:0] w_mag;
  logic [63:0] w_signed_prod;
  logic [63:0] w_result;

  // Highest-priority asserted op wins when several are raised together.
  always_comb begin
    w_start  = OP_mult | OP_multu | OP_madd | OP_maddu | OP_msub | OP_msubu;
    w_signed = 1'b0;
    w_mode   = M_NONE;
    if (OP_mult) begin
      w_signed = 1'b1;
      w_mode   = M_NONE;
    end else if (OP_multu) begin
      w_signed = 1'b0;
      w_mode   = M_NONE;
    end else if (OP_madd) begin
      w_signed = 1'b1;
      w_mode   = M_ADD;
    end else if (OP_maddu) begin
      w_signed = 1'b0;
      w_mode   = M_ADD;
    end else if (OP_msub) begin
      w_signed = 1'b1;
      w_mode   = M_SUB;
    end else if (OP_msubu) begin
      w_signed = 1'b0;
      w_mode   = M_SUB;
    end
  end

  assign w_abs_a  = (w_signed && Multiplicand[31]) ? (~Multiplicand + 32'd1) : Multiplicand;
  assign w_abs_b  = (w_signed && Multiplier[31])   ? (~Multiplier + 32'd1)   : Multiplier;
  assign w_addend = r_lo[0] ? r_mcand : 32'd0;
  assign w_sum    = {1'b0, r_hi} + {1'b0, w_addend};

  always_comb begin
    w_state_nxt  = r_state;
    w_cycle_nxt  = r_cycle;
    w_neg_nxt    = r_neg;
    w_mode_nxt   = r_mode;
    w_mcand_nxt  = r_mcand;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    w_acc_in_nxt = r_acc_in;
    if (w_start) begin
      // A start in either state restarts from fresh operands.
      w_state_nxt  = S_RUN;
      w_cycle_nxt  = 5'd31;
      w_neg_nxt    = w_signed & (Multiplicand[31] ^ Multiplier[31]);
      w_mode_nxt   = w_mode;
      w_mcand_nxt  = w_abs_a;
      w_hi_nxt     = 32'd0;
      w_lo_nxt     = w_abs_b;
      w_acc_in_nxt = {HI_in, LO_in};
    end else if (r_state == S_RUN) begin
      w_hi_nxt    = w_sum[32:1];
      w_lo_nxt    = {w_sum[0], r_lo[31:1]};
      w_cycle_nxt = r_cycle - 5'd1;
      if (r_cycle == 5'd0) begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cycle  <= 5'd0;
      r_neg    <= 1'b0;
      r_mode   <= M_NONE;
      r_mcand  <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_acc_in <= 64'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cycle  <= w_cycle_nxt;
      r_neg    <= w_neg_nxt;
      r_mode   <= w_mode_nxt;
      r_mcand  <= w_mcand_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_acc_in <= w_acc_in_nxt;
    end
  end

  assign w_mag         = {r_hi, r_lo};
  assign w_signed_prod = r_neg ? (~w_mag + 64'd1) : w_mag;

  always_comb begin
    w_result = w_signed_prod;
    case (r_mode)
      M_ADD:   w_result = r_acc_in + w_signed_prod;
      M_SUB:   w_result = r_acc_in - w_signed_prod;
      default: w_result = w_signed_prod;
    endcase
  end

  assign Product_HI = w_result[63:32];
  assign Product_LO = w_result[31:0];
  assign Stall      = (r_state == S_RUN);

endmodule

// File: tb/tb_multicycle_multiply.sv
// tb/tb_multicycle_multiply.sv - scoreboard bench for multicycle_multiply
module tb_multicycle_multiply;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  ops = 6'd0;
  logic [31:0] Multiplicand = 32'd0;
  logic [31:0] Multiplier = 32'd0;
  logic [31:0] HI_in = 32'd0;
  logic [31:0] LO_in = 32'd0;
  logic [31:0] Product_HI;
  logic [31:0] Product_LO;
  logic        Stall;

  int total = 0;
  int bad = 0;
  logic [63:0] sb[$];

  localparam logic [5:0] OPC_MULT  = 6'b000001;
  localparam logic [5:0] OPC_MULTU = 6'b000010;
  localparam logic [5:0] OPC_MADD  = 6'b000100;
  localparam logic [5:0] OPC_MADDU = 6'b001000;
  localparam logic [5:0] OPC_MSUB  = 6'b010000;
  localparam logic [5:0] OPC_MSUBU = 6'b100000;

  multicycle_multiply dut (
    .clock        (clock),
    .reset        (reset),
    .OP_mult      (ops[0]),
    .OP_multu     (ops[1]),
    .OP_madd      (ops[2]),
    .OP_maddu     (ops[3]),
    .OP_msub      (ops[4]),
    .OP_msubu     (ops[5]),
    .Multiplicand (Multiplicand),
    .Multiplier   (Multiplier),
    .HI_in        (HI_in),
    .LO_in        (LO_in),
    .Product_HI   (Product_HI),
    .Product_LO   (Product_LO),
    .Stall        (Stall)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] hi, input logic [31:0] lo);
    logic sgn;
    int   md;
    logic signed [63:0] sa, sb_v;
    logic [63:0] p;
    logic [63:0] acc;
    sgn = 1'b0;
    md  = 0;
    if (op[0])      begin sgn = 1'b1; md = 0; end
    else if (op[1]) begin sgn = 1'b0; md = 0; end
    else if (op[2]) begin sgn = 1'b1; md = 1; end
    else if (op[3]) begin sgn = 1'b0; md = 1; end
    else if (op[4]) begin sgn = 1'b1; md = 2; end
    else            begin sgn = 1'b0; md = 2; end
    if (sgn) begin
      sa   = {{32{a[31]}}, a};
      sb_v = {{32{b[31]}}, b};
      p    = sa * sb_v;
    end else begin
      p = {32'd0, a} * {32'd0, b};
    end
    acc = {hi, lo};
    if (md == 1)      return acc + p;
    else if (md == 2) return acc - p;
    return p;
  endfunction

  // Called away from the rising edge; op pulses for exactly one rising edge.
  task automatic start(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo);
    ops          = op;
    Multiplicand = a;
    Multiplier   = b;
    HI_in        = hi;
    LO_in        = lo;
    sb.push_back(model(op, a, b, hi, lo));
    @(posedge clock);
    #1 ops = 6'd0;
  endtask

  task automatic wait_done(input string tag);
    int cnt;
    logic [63:0] exp;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!Stall) break;
      cnt++;
    end
    check_val({tag, "_stall_cycles"}, 64'(cnt), 64'd32);
    if (sb.size() == 0) begin
      check_val({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
    end else begin
      exp = sb.pop_front();
      check_val(tag, {Product_HI, Product_LO}, exp);
    end
  endtask

  initial begin
    logic [63:0] held;
    logic [31:0] ra, rb, rh, rl;
    // Reset wins over a simultaneous start.
    ops = OPC_MULTU;
    Multiplicand = 32'd3;
    Multiplier = 32'd3;
    @(posedge clock);
    #1 ops = 6'd0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_val("reset_stall", 64'(Stall), 64'd0);
    check_val("reset_prod", {Product_HI, Product_LO}, 64'd0);

    start(OPC_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0);
    wait_done("multu_max");
    held = {Product_HI, Product_LO};
    repeat (3) @(negedge clock);
    check_val("multu_hold", {Product_HI, Product_LO}, held);
    check_val("multu_hold_stall", 64'(Stall), 64'd0);

    // Back-to-back chain: each start issued on the cycle the previous Stall falls.
    start(OPC_MULT, 32'hFFFFFFFD, 32'd5, 32'd0, 32'd0);
    wait_done("mult_neg3x5");
    start(OPC_MULT, 32'h80000000, 32'h80000000, 32'd0, 32'd0);
    wait_done("mult_minmin");
    start(OPC_MADDU, 32'd1, 32'd1, 32'h00000000, 32'hFFFFFFFF);
    wait_done("maddu_carry");
    start(OPC_MSUB, 32'd2, 32'd3, 32'd0, 32'd0);
    wait_done("msub_2x3");
    start(OPC_MULT | OPC_MULTU, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0);
    wait_done("prio_mult");
    start(OPC_MADD | OPC_MSUBU, 32'hFFFFFFF0, 32'd7, 32'd100, 32'd5);
    wait_done("prio_madd");

    // Abort: restart during RUN drops the pending result.
    start(OPC_MULTU, 32'd7, 32'd9, 32'd0, 32'd0);
    repeat (10) @(negedge clock);
    check_val("abort_midstall", 64'(Stall), 64'd1);
    void'(sb.pop_back());
    start(OPC_MULT, 32'd4, 32'hFFFFFFFE, 32'd0, 32'd0);
    wait_done("abort_restart");

    // Reset mid-run.
    @(negedge clock);
    start(OPC_MULTU, 32'h12345678, 32'h9ABCDEF0, 32'd0, 32'd0);
    repeat (15) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_val("midreset_stall", 64'(Stall), 64'd0);
    check_val("midreset_prod", {Product_HI, Product_LO}, 64'd0);
    sb.delete();
    start(OPC_MULTU, 32'd6, 32'd7, 32'd0, 32'd0);
    wait_done("post_reset_6x7");

    // Random coverage of every op type.
    for (int k = 0; k < 12; k++) begin
      ra = $urandom;
      rb = $urandom;
      rh = $urandom;
      rl = $urandom;
      start(6'(1 << (k % 6)), ra, rb, rh, rl);
      wait_done($sformatf("rand_%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
